ebi_bus_bridge: RTL and testbench

// Consumes the decoded EBI strobes and word address produced by the PPC external-bus interface.

---
 rtl/ebi_bridge_pkg.sv | 26 ++
 rtl/ebi_sync2.sv | 33 +++
 rtl/ebi_bus_bridge.sv | 185 ++++++++++++++++++
 tb/tb_ebi_bus_bridge.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ebi_bridge_pkg.sv
// ============================================================================
// Module   : ebi_bridge_pkg
// Purpose  : Shared types and constants for the EBI-to-switch-register-bus
//            bridge: FSM state encoding, full byte-enable mask and default
//            timeout / read-error values.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ebi_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WR_REQ = 2'd1,
    ST_RD_REQ = 2'd2,
    ST_REL    = 2'd3
  } state_t;

  localparam logic [3:0]  BE_ALL         = 4'hF;
  localparam int          TMO_CYCLES_DEF = 255;
  localparam logic [31:0] RD_ERR_VAL_DEF = 32'hDEAD_BEEF;

endpackage

`default_nettype wire

// File: rtl/ebi_sync2.sv
// ============================================================================
// Module   : ebi_sync2
// Purpose  : Generic two-flop synchroniser for a single asynchronous level.
// Ports    : clk   - destination clock
//            rst_n - asynchronous active-low reset (output forced to 0)
//            d     - asynchronous input level
//            q     - synchronised level, two clk cycles of latency
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ebi_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ebi_bus_bridge.sv
// ============================================================================
// Module   : ebi_bus_bridge
// Purpose  : Converts the asynchronous EBI read/write strobes into single
//            req/ack transactions on the internal switch register bus, returns
//            read data to the PPC data bus and flags timeouts / protocol errors.
// Ports    : clk, rst_n          - clock, async active-low reset
//            re_i, we_i          - async EBI read / write strobes (level)
//            addr_i, wdata_i     - EBI word address and write data
//            we_n_i              - EBI byte write enables (active low)
//            rdata_o, rdata_oe_o - read data and output enable to the PPC bus
//            bus_req_o .. bus_wdata_o - internal bus request side
//            bus_ack_i, bus_rdata_i   - internal bus response side
//            err_o, err_clr_i    - sticky error flag and its clear
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ebi_bus_bridge
  import ebi_bridge_pkg::*;
#(
  parameter int                ADDR_W     = 22,
  parameter int                DATA_W     = 32,
  parameter int                TMO_CYCLES = TMO_CYCLES_DEF,
  parameter logic [DATA_W-1:0] RD_ERR_VAL = DATA_W'(RD_ERR_VAL_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              re_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [3:0]        we_n_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rdata_oe_o,
  output logic              bus_req_o,
  output logic              bus_wr_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_be_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic              bus_ack_i,
  input  logic [DATA_W-1:0] bus_rdata_i,
  output logic              err_o,
  input  logic              err_clr_i
);

  // Last value of the timeout counter before the abort fires; with the
  // counter cleared on REQ entry this gives exactly TMO_CYCLES request cycles.
  localparam logic [7:0] TMO_LAST = 8'(TMO_CYCLES - 1);

  logic       re_s, we_s;
  logic       re_d, we_d;
  logic [1:0] settle;
  logic       re_armed, we_armed;
  logic       re_rise_q, we_rise_q;

  state_t     state, state_nxt;
  logic [7:0] tmo_cnt;
  logic       start_wr, start_rd, ack_hit, tmo_hit, set_err;

  ebi_sync2 u_sync_re (.clk(clk), .rst_n(rst_n), .d(re_i), .q(re_s));
  ebi_sync2 u_sync_we (.clk(clk), .rst_n(rst_n), .d(we_i), .q(we_s));

  // Edge detection. The synchronisers come out of reset at 0, so a strobe
  // still held high across reset would look like a fresh rising edge. A
  // strobe is therefore only armed once its synchronised level has been seen
  // low after the chain has flushed (settle == 2). The edge pulse is
  // registered so the request starts three edges after the strobe is sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      re_d      <= 1'b0;
      we_d      <= 1'b0;
      settle    <= 2'd0;
      re_armed  <= 1'b0;
      we_armed  <= 1'b0;
      re_rise_q <= 1'b0;
      we_rise_q <= 1'b0;
    end else begin
      re_d <= re_s;
      we_d <= we_s;
      if (settle != 2'd2) begin
        settle <= settle + 2'd1;
      end
      if (settle == 2'd2 && !re_s) begin
        re_armed <= 1'b1;
      end
      if (settle == 2'd2 && !we_s) begin
        we_armed <= 1'b1;
      end
      re_rise_q <= re_armed & re_s & ~re_d;
      we_rise_q <= we_armed & we_s & ~we_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    bus_req_o  = 1'b0;
    rdata_oe_o = 1'b0;
    start_wr   = 1'b0;
    start_rd   = 1'b0;
    ack_hit    = 1'b0;
    tmo_hit    = 1'b0;
    set_err    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (we_rise_q) begin
          // Simultaneous strobes: the write wins and the collision is flagged.
          start_wr  = 1'b1;
          set_err   = re_rise_q;
          state_nxt = ST_WR_REQ;
        end else if (re_rise_q) begin
          start_rd  = 1'b1;
          state_nxt = ST_RD_REQ;
        end
      end
      ST_WR_REQ, ST_RD_REQ: begin
        bus_req_o = 1'b1;
        set_err   = we_rise_q | re_rise_q;
        if (bus_ack_i) begin
          ack_hit   = 1'b1;
          state_nxt = ST_REL;
        end else if (tmo_cnt == TMO_LAST) begin
          tmo_hit   = 1'b1;
          set_err   = 1'b1;
          state_nxt = ST_REL;
        end
      end
      ST_REL: begin
        rdata_oe_o = ~bus_wr_o & re_s;
        set_err    = we_rise_q | re_rise_q;
        if (!(bus_wr_o ? we_s : re_s)) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_wr_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_be_o    <= 4'h0;
      bus_wdata_o <= '0;
      rdata_o     <= '0;
      tmo_cnt     <= 8'h00;
      err_o       <= 1'b0;
    end else begin
      // Address/data have been stable for >= 2 clk by the time the edge is
      // seen, so they are sampled directly and held until the next access.
      if (start_wr || start_rd) begin
        bus_wr_o    <= start_wr;
        bus_addr_o  <= addr_i;
        bus_wdata_o <= wdata_i;
        bus_be_o    <= start_wr ? ~we_n_i : BE_ALL;
        tmo_cnt     <= 8'h00;
      end else if (bus_req_o && tmo_cnt != 8'hFF) begin
        tmo_cnt <= tmo_cnt + 8'd1;
      end

      // Read data is only kept if the PPC is still waiting for it.
      if (ack_hit && !bus_wr_o && re_s) begin
        rdata_o <= bus_rdata_i;
      end else if (tmo_hit && !bus_wr_o) begin
        rdata_o <= RD_ERR_VAL;
      end

      if (set_err) begin
        err_o <= 1'b1;
      end else if (err_clr_i) begin
        err_o <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ebi_bus_bridge.sv
// ============================================================================
// Module   : tb_ebi_bus_bridge
// Purpose  : Scoreboard testbench for ebi_bus_bridge. Stimulus pushes the
//            expected bus request and read data into queues; monitors pop and
//            compare whenever the DUT raises bus_req_o or rdata_oe_o.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ebi_bus_bridge;

  localparam int ADDR_W = 22;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              re_i = 1'b0;
  logic              we_i = 1'b0;
  logic [ADDR_W-1:0] addr_i = '0;
  logic [DATA_W-1:0] wdata_i = '0;
  logic [3:0]        we_n_i = 4'hF;
  logic [DATA_W-1:0] rdata_o;
  logic              rdata_oe_o;
  logic              bus_req_o;
  logic              bus_wr_o;
  logic [ADDR_W-1:0] bus_addr_o;
  logic [3:0]        bus_be_o;
  logic [DATA_W-1:0] bus_wdata_o;
  logic              bus_ack_i = 1'b0;
  logic [DATA_W-1:0] bus_rdata_i = 32'h0BAD_0BAD;
  logic              err_o;
  logic              err_clr_i = 1'b0;

  ebi_bus_bridge dut (
    .clk(clk), .rst_n(rst_n), .re_i(re_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .we_n_i(we_n_i), .rdata_o(rdata_o), .rdata_oe_o(rdata_oe_o),
    .bus_req_o(bus_req_o), .bus_wr_o(bus_wr_o), .bus_addr_o(bus_addr_o),
    .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o), .bus_ack_i(bus_ack_i),
    .bus_rdata_i(bus_rdata_i), .err_o(err_o), .err_clr_i(err_clr_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        be;
    logic [DATA_W-1:0] wdata;
    logic              chk_wdata;
  } req_t;

  req_t              exp_req_q[$];
  logic [DATA_W-1:0] exp_rd_q[$];

  int n_checks = 0;
  int n_errors = 0;

  int req_pulses = 0, req_run = 0, last_req_len = 0;
  int oe_pulses = 0, oe_run = 0, last_oe_len = 0;
  logic req_prev = 1'b0, oe_prev = 1'b0;

  int                ack_delay = -1;
  logic [DATA_W-1:0] ack_rdata = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_req(input logic wr, input logic [ADDR_W-1:0] a, input logic [3:0] be,
                          input logic [DATA_W-1:0] d, input logic chk_d);
    req_t e;
    e.wr = wr; e.addr = a; e.be = be; e.wdata = d; e.chk_wdata = chk_d;
    exp_req_q.push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold the selected strobe(s) high for 'hi' clk, then low for 'gap' clk.
  task automatic strobe(input logic wr, input logic rd, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input logic [3:0] wen,
                        input int hi, input int gap);
    addr_i = a; wdata_i = d; we_n_i = wen;
    we_i = wr; re_i = rd;
    cyc(hi);
    we_i = 1'b0; re_i = 1'b0;
    cyc(gap);
  endtask

  // Request / read-data monitor.
  initial begin
    req_t e;
    logic [DATA_W-1:0] r;
    forever begin
      @(negedge clk);
      if (bus_req_o && !req_prev) begin
        req_pulses++;
        if (exp_req_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_req: got addr 0x%0h wr %0b, no request expected", bus_addr_o, bus_wr_o);
        end else begin
          e = exp_req_q.pop_front();
          check("req_wr", 64'(bus_wr_o), 64'(e.wr));
          check("req_addr", 64'(bus_addr_o), 64'(e.addr));
          check("req_be", 64'(bus_be_o), 64'(e.be));
          if (e.chk_wdata) check("req_wdata", 64'(bus_wdata_o), 64'(e.wdata));
        end
      end
      if (!bus_req_o && req_prev) last_req_len = req_run;
      req_run  = bus_req_o ? req_run + 1 : 0;
      req_prev = bus_req_o;

      if (rdata_oe_o && !oe_prev) begin
        oe_pulses++;
        if (exp_rd_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_oe: got rdata 0x%0h, no read data expected", rdata_o);
        end else begin
          r = exp_rd_q.pop_front();
          check("rdata", 64'(rdata_o), 64'(r));
        end
      end
      if (!rdata_oe_o && oe_prev) last_oe_len = oe_run;
      oe_run  = rdata_oe_o ? oe_run + 1 : 0;
      oe_prev = rdata_oe_o;
    end
  end

  // Bus responder: single-cycle ack 'ack_delay' clk after req rises.
  initial begin
    int age = 0;
    forever begin
      @(negedge clk);
      bus_ack_i   = 1'b0;
      bus_rdata_i = 32'h0BAD_0BAD;
      age = bus_req_o ? age + 1 : 0;
      if (bus_req_o && ack_delay > 0 && age == ack_delay) begin
        bus_ack_i   = 1'b1;
        bus_rdata_i = ack_rdata;
      end
    end
  end

  initial begin
    int p0, o0;
    cyc(3);
    check("rst_req", 64'(bus_req_o), 64'(0));
    check("rst_oe", 64'(rdata_oe_o), 64'(0));
    check("rst_rdata", 64'(rdata_o), 64'(0));
    check("rst_addr", 64'(bus_addr_o), 64'(0));
    check("rst_misc", 64'({bus_wr_o, bus_be_o, err_o}), 64'(0));
    check("rst_wdata", 64'(bus_wdata_o), 64'(0));
    rst_n = 1'b1;
    cyc(6);

    // 1: full-word write
    p0 = req_pulses; ack_delay = 2;
    push_req(1'b1, 22'h00_0010, 4'hF, 32'h1234_5678, 1'b1);
    strobe(1'b1, 1'b0, 22'h00_0010, 32'h1234_5678, 4'b0000, 6, 6);
    check("t1_pulses", 64'(req_pulses - p0), 64'(1));
    check("t1_req_len", 64'(last_req_len), 64'(2));
    check("t1_err", 64'(err_o), 64'(0));

    // 2: read with ack
    p0 = req_pulses; o0 = oe_pulses; ack_rdata = 32'hA5A5_0F0F;
    push_req(1'b0, 22'h3F_FFFF, 4'hF, '0, 1'b0);
    exp_rd_q.push_back(32'hA5A5_0F0F);
    strobe(1'b0, 1'b1, 22'h3F_FFFF, 32'h0, 4'hF, 10, 6);
    check("t2_pulses", 64'(req_pulses - p0), 64'(1));
    check("t2_oe_pulses", 64'(oe_pulses - o0), 64'(1));
    check("t2_oe_len", 64'(last_oe_len), 64'(6));
    check("t2_err", 64'(err_o), 64'(0));

    // 3: read timeout
    ack_delay = -1;
    push_req(1'b0, 22'h00_0155, 4'hF, '0, 1'b0);
    exp_rd_q.push_back(32'hDEAD_BEEF);
    strobe(1'b0, 1'b1, 22'h00_0155, 32'h0, 4'hF, 270, 6);
    check("t3_req_len", 64'(last_req_len), 64'(255));
    check("t3_rdata", 64'(rdata_o), 64'(32'hDEAD_BEEF));
    check("t3_err_set", 64'(err_o), 64'(1));
    err_clr_i = 1'b1;
    cyc(1);
    err_clr_i = 1'b0;
    check("t3_err_clr", 64'(err_o), 64'(0));

    // 4: byte-lane write followed by a second write after a 3-clk gap
    p0 = req_pulses; ack_delay = 3;
    push_req(1'b1, 22'h2A_AAAA, 4'b0010, 32'hCAFE_F00D, 1'b1);
    push_req(1'b1, 22'h15_5555, 4'b1001, 32'h0BEE_F123, 1'b1);
    strobe(1'b1, 1'b0, 22'h2A_AAAA, 32'hCAFE_F00D, 4'b1101, 6, 3);
    strobe(1'b1, 1'b0, 22'h15_5555, 32'h0BEE_F123, 4'b0110, 6, 6);
    check("t4_pulses", 64'(req_pulses - p0), 64'(2));
    check("t4_err", 64'(err_o), 64'(0));

    // 5a: read and write strobes rise together
    p0 = req_pulses; o0 = oe_pulses; ack_delay = 2;
    push_req(1'b1, 22'h00_0ABC, 4'hF, 32'h5555_AAAA, 1'b1);
    strobe(1'b1, 1'b1, 22'h00_0ABC, 32'h5555_AAAA, 4'b0000, 6, 6);
    check("t5a_pulses", 64'(req_pulses - p0), 64'(1));
    check("t5a_no_oe", 64'(oe_pulses - o0), 64'(0));
    check("t5a_err", 64'(err_o), 64'(1));
    err_clr_i = 1'b1;
    cyc(1);
    err_clr_i = 1'b0;

    // 5b: read strobe drops before the late ack
    p0 = req_pulses; o0 = oe_pulses; ack_delay = 6; ack_rdata = 32'h1111_2222;
    push_req(1'b0, 22'h00_0333, 4'hF, '0, 1'b0);
    strobe(1'b0, 1'b1, 22'h00_0333, 32'h0, 4'hF, 4, 10);
    check("t5b_pulses", 64'(req_pulses - p0), 64'(1));
    check("t5b_no_oe", 64'(oe_pulses - o0), 64'(0));
    check("t5b_rdata_kept", 64'(rdata_o), 64'(32'hDEAD_BEEF));
    check("t5b_err", 64'(err_o), 64'(0));

    // 6: reset during RD_REQ with the strobe held through reset
    ack_delay = -1;
    push_req(1'b0, 22'h01_2345, 4'hF, '0, 1'b0);
    addr_i = 22'h01_2345; re_i = 1'b1;
    cyc(5);
    check("t6_req_before_rst", 64'(bus_req_o), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_req", 64'(bus_req_o), 64'(0));
    check("t6_rst_outs", 64'({rdata_oe_o, bus_wr_o, bus_be_o, err_o}), 64'(0));
    check("t6_rst_rdata", 64'(rdata_o), 64'(0));
    check("t6_rst_addr", 64'(bus_addr_o), 64'(0));
    cyc(2);
    rst_n = 1'b1;
    p0 = req_pulses;
    cyc(20);
    check("t6_no_req_held", 64'(req_pulses - p0), 64'(0));
    re_i = 1'b0;
    cyc(5);
    ack_delay = 2; ack_rdata = 32'h600D_CAFE;
    push_req(1'b0, 22'h01_2345, 4'hF, '0, 1'b0);
    exp_rd_q.push_back(32'h600D_CAFE);
    strobe(1'b0, 1'b1, 22'h01_2345, 32'h0, 4'hF, 8, 6);
    check("t6_new_req", 64'(req_pulses - p0), 64'(1));
    check("t6_rdata", 64'(rdata_o), 64'(32'h600D_CAFE));

    check("req_queue_drained", 64'(exp_req_q.size()), 64'(0));
    check("rd_queue_drained", 64'(exp_rd_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
